// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit driving a single-port word memory.
// Sub-word stores are done as a read-modify-write; loads are extended to 32 bits.
module load_store_unit #(
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t      state;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] word;
  logic [2:0]  funct3;
  logic        we;

  logic        misaligned;
  logic        illegal;
  logic        out_of_range;
  logic        bad_req;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] store_word;

  assign req_ready = (state == IDLE);

  always_comb begin
    misaligned = 1'b0;
    case (req_funct3)
      3'b001, 3'b101: misaligned = req_addr[0];
      3'b010:         misaligned = (req_addr[1:0] != 2'b00);
      default:        misaligned = 1'b0;
    endcase
    if (req_we)
      illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    else
      illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
    out_of_range = ((req_addr >> (MEM_ADDR_WIDTH + 2)) != 32'd0);
    bad_req      = misaligned || illegal || out_of_range;
  end

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] a,
                                         input logic [31:0] w);
    logic [31:0] bsh;
    logic [31:0] hsh;
    bsh = w >> {a, 3'b000};
    hsh = w >> {a[1], 4'b0000};
    case (f3)
      3'b000:  extend = {{24{bsh[7]}}, bsh[7:0]};
      3'b001:  extend = {{16{hsh[15]}}, hsh[15:0]};
      3'b100:  extend = {24'h0, bsh[7:0]};
      3'b101:  extend = {16'h0, hsh[15:0]};
      default: extend = w;
    endcase
  endfunction

  // Merge the store lane into the word captured during ACCESS; SW replaces it all.
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        lane_mask = 32'h0000_00FF << {addr[1:0], 3'b000};
        lane_data = {24'h0, wdata[7:0]} << {addr[1:0], 3'b000};
      end
      2'b01: begin
        lane_mask = 32'h0000_FFFF << {addr[1], 4'b0000};
        lane_data = {16'h0, wdata[15:0]} << {addr[1], 4'b0000};
      end
      default: begin
        lane_mask = 32'hFFFF_FFFF;
        lane_data = wdata;
      end
    endcase
    store_word = (word & ~lane_mask) | lane_data;
  end

  always_comb begin
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (state == ACCESS || state == WRITE)
      mem_addr = {addr[31:2], 2'b00};
    if (state == WRITE)
      mem_wdata = store_word;
  end

  // Gating with reset keeps a reset landing in WRITE from corrupting memory.
  assign mem_rw = (state == WRITE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= 32'h0;
      wdata     <= 32'h0;
      word      <= 32'h0;
      funct3    <= 3'b000;
      we        <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr   <= req_addr;
            wdata  <= req_wdata;
            funct3 <= req_funct3;
            we     <= req_we;
            if (bad_req || req_we)
              rsp_rdata <= 32'h0;
            if (bad_req) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (req_we && req_funct3 == 3'b010) begin
              state <= WRITE;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          word <= mem_rdata;
          if (we) begin
            state <= WRITE;
          end else begin
            rsp_rdata <= extend(funct3, addr[1:0], mem_rdata);
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        WRITE: begin
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a word-array reference model.
module tb_load_store_unit;
  localparam int AW = 10;
  localparam int NW = 1 << AW;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rw;
  logic [31:0] mem_rdata;

  logic [31:0] mem [NW];
  logic [31:0] ref_mem [NW];

  typedef struct {logic [31:0] rdata; logic err; int lat; longint t;} rsp_t;
  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  longint last_acc;

  load_store_unit #(.MEM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[AW+1:2]];
  always @(posedge clk) if (mem_rw) mem[mem_addr[AW+1:2]] <= mem_wdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: size/alignment/range rules and lane arithmetic on a plain word array.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] d, input longint t);
    rsp_t r;
    wr_t  w;
    int sz, k;
    bit bad;
    logic [31:0] word, v, mask;
    bad = we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz = 1 << f3[1:0];
    if ((a & (sz - 1)) != 0) bad = 1;
    if ({32'h0, a} >= (64'd4 << AW)) bad = 1;
    r.t = t; r.rdata = 32'h0; r.err = bad; r.lat = 1;
    if (!bad) begin
      word = ref_mem[a[AW+1:2]];
      k = int'(a[1:0]);
      if (!we) begin
        r.lat = 2;
        if (sz == 4) v = word;
        else begin
          mask = (sz == 1) ? 32'hFF : 32'hFFFF;
          v = (word >> (8 * k)) & mask;
          if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        end
        r.rdata = v;
      end else begin
        if (sz == 4) begin
          v = d; r.lat = 2;
        end else begin
          mask = ((sz == 1) ? 32'hFF : 32'hFFFF) << (8 * k);
          v = (word & ~mask) | ((d << (8 * k)) & mask);
          r.lat = 3;
        end
        ref_mem[a[AW+1:2]] = v;
        w.addr = a & 32'hFFFF_FFFC; w.data = v;
        wr_q.push_back(w);
      end
    end
    rsp_q.push_back(r);
  endfunction

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input bit use_model);
    bit got = 0;
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d; req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin got = 1; break; end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1");
      return;
    end
    @(posedge clk);
    last_acc = $time;
    if (use_model) model(we, f3, a, d, $time);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    rsp_t e;
    wr_t  w;
    if (mem_rw) begin
      if (wr_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: got addr %h data %h expected none", mem_addr, mem_wdata);
      end else begin
        w = wr_q.pop_front();
        check("write_addr_data", {mem_addr, mem_wdata}, {w.addr, w.data});
      end
    end
    if (rsp_valid) begin
      if (rsp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0");
      end else begin
        e = rsp_q.pop_front();
        check("rsp_rdata", {32'h0, rsp_rdata}, {32'h0, e.rdata});
        check("rsp_err", {63'h0, rsp_err}, {63'h0, e.err});
        check("rsp_latency", 64'(($time - e.t + 5) / 10), 64'(e.lat));
      end
    end
  end

  initial begin
    longint t0, t1, t2;
    logic [31:0] a, d;
    logic [2:0] f3;
    logic we;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < NW; i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    mem[0] = 32'hF00D1234; ref_mem[0] = 32'hF00D1234;
    mem[1] = 32'h8899AABB; ref_mem[1] = 32'h8899AABB;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    check("reset_rsp_err", {63'h0, rsp_err}, 64'h0);
    check("reset_rsp_rdata", {32'h0, rsp_rdata}, 64'h0);
    check("reset_mem_rw", {63'h0, mem_rw}, 64'h0);
    check("reset_req_ready", {63'h0, req_ready}, 64'h1);
    @(posedge clk); #1 reset = 1'b0;

    issue(1'b0, 3'b000, 32'h5, 32'h0, 1);             // LB -> FFFFFFAA
    idle_cycles(3);
    issue(1'b1, 3'b000, 32'h6, 32'h12, 1);            // SB -> 8812AABB
    idle_cycles(4);
    issue(1'b0, 3'b010, 32'h4, 32'h0, 1);             // LW
    idle_cycles(3);
    issue(1'b0, 3'b101, 32'h2, 32'h0, 1);             // LHU -> 0000F00D
    idle_cycles(3);
    issue(1'b0, 3'b001, 32'h2, 32'h0, 1);             // LH -> FFFFF00D
    idle_cycles(3);
    issue(1'b1, 3'b010, 32'h3, 32'hDEADBEEF, 1);      // misaligned SW
    idle_cycles(2);
    issue(1'b0, 3'b010, 32'h1 << (AW + 2), 32'h0, 1); // out of range LW
    idle_cycles(2);
    issue(1'b0, 3'b011, 32'h8, 32'h0, 1);             // illegal funct3
    idle_cycles(2);

    // Reset while the SH sits in WRITE: no write and no response may follow.
    issue(1'b1, 3'b001, 32'h10, 32'hCAFE, 0);
    req_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("abort_mem_rw", {63'h0, mem_rw}, 64'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_req_ready", {63'h0, req_ready}, 64'h1);
    repeat (3) @(posedge clk);
    #1;
    check("abort_mem_unchanged", {32'h0, mem[4]}, {32'h0, ref_mem[4]});

    // Three SW with req_valid held high throughout.
    issue(1'b1, 3'b010, 32'h20, 32'h11111111, 1); t0 = last_acc;
    issue(1'b1, 3'b010, 32'h24, 32'h22222222, 1); t1 = last_acc;
    issue(1'b1, 3'b010, 32'h28, 32'h33333333, 1); t2 = last_acc;
    check("b2b_spacing_1", 64'((t1 - t0) / 10), 64'd3);
    check("b2b_spacing_2", 64'((t2 - t1) / 10), 64'd3);
    idle_cycles(3);

    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2)) | (we ? 3'b000 : {1'($urandom_range(0, 1)), 2'b00});
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = (32'h1 << (AW + 2)) | 32'($urandom_range(0, 63));
        default: a = 32'($urandom_range(0, 63));
      endcase
      d = $urandom;
      issue(we, f3, a, d, 1);
      if ($urandom_range(0, 2) != 0) idle_cycles($urandom_range(0, 3));
    end
    req_valid = 1'b0;

    for (int i = 0; i < 20 && (rsp_q.size() != 0 || wr_q.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    check("rsp_queue_drained", 64'(rsp_q.size()), 64'h0);
    check("write_queue_drained", 64'(wr_q.size()), 64'h0);
    for (int i = 0; i < NW; i++)
      if (mem[i] !== ref_mem[i]) check("final_memory", {32'(i), mem[i]}, {32'(i), ref_mem[i]});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
